sr_io_scheduler: RTL
====================

# sr_io_scheduler

Arbitrates writes to the 24-bit serial shift-register output word between `NREQ` requesters and commits them coherently at frame boundaries. It also snapshots and debounces the 24 input bits once per frame and flags changes. It sits directly above the shift-register controller. It drives that controller's `out0..out23` from `out_word`, takes its `in0..in23` as `in_word`, and watches its `bitcount` to find frame boundaries.

## Interface
Parameters:
- `NREQ`, 2: number of write requesters, 2..4.
- `DEBOUNCE`, 3: number of consecutive identical frame snapshots required before a stable input bit updates, 1..3.

Ports:
- `CLK_IN`  in  1  shift-register clock; the only clock.
- `RST`  in  1  reset, synchronous, active-high.
- `bitcount`  in  5  frame bit counter from the shift-register controller, values 0..24.
- `req_valid`  in  NREQ  per-requester write request.
- `req_mask`  in  24*NREQ  per-requester bit-enable; requester i occupies bits [24i+23:24i].
- `req_data`  in  24*NREQ  per-requester write data, same packing as `req_mask`.
- `req_ready`  out  NREQ  one-cycle accept pulse, one-hot or zero.
- `out_word`  out  24  committed output word, bit n drives `out{n}`.
- `pending`  out  24  shadow word awaiting commit.
- `in_word`  in  24  raw input bits, bit n from `in{n}`.
- `in_stable`  out  24  debounced input word.
- `in_changed`  out  1  one-cycle pulse when any `in_stable` bit changes.
- `change_mask`  out  24  bits that changed at the last `in_changed` pulse; held until the next pulse.
- `frame_cnt`  out  16  number of committed frames, wraps modulo 2^16.

## Operation
- Reset values: `req_ready`=0, `out_word`=0, `pending`=0, `in_stable`=0, `in_changed`=0, `change_mask`=0, `frame_cnt`=0, round-robin pointer=0, all debounce counters=0, state=ARB.
- Arbiter FSM, two states:
  - ARB: if any `req_valid`, grant the first valid index at or after the pointer, searching modulo NREQ. Register the grant and go to ACK. Otherwise stay in ARB.
  - ACK: assert `req_ready[grant]` for this cycle only and set `pending <= (pending & ~mask_g) | (data_g & mask_g)`. Set pointer <= (grant+1) mod NREQ and return to ARB.
- Handshake:
  - A requester holds `req_valid`, mask and data stable until it sees `req_ready`.
  - Mask and data are sampled in the ACK cycle.
  - Dropping `req_valid` between grant and ACK still completes the ACK with the data present in the ACK cycle.
  - Throughput is at most one accept per 2 cycles.
- Commit: on a cycle with `bitcount==24`, set `out_word <= pending` and `frame_cnt <= frame_cnt+1`.
  - The commit uses the value of `pending` before that cycle's merge.
  - A merge in the same cycle as a commit appears in the next frame.
- Snapshot: on a cycle with `bitcount==0`, `in_word` holds the complete previous frame. Each bit is then processed:
  - If the snapshot bit != `in_stable[n]`, increment that bit's counter.
  - Otherwise clear that bit's counter.
  - When the counter reaches DEBOUNCE, flip `in_stable[n]` and clear the counter.
- `in_changed` pulses in the cycle after any flip. `change_mask` is loaded with the flipped bits in that same cycle.
- `bitcount` values 25..31 cause neither a commit nor a snapshot.
- `RST` asserted mid-operation returns every register to its reset value on the next edge. An in-progress ACK is discarded with no `req_ready` pulse.

## Timing
- Request latency: `req_valid` seen in ARB at edge k produces `req_ready` high during cycle k+1.
- Commit latency: `out_word` changes on the edge that samples `bitcount==24`, so the controller samples bit 0 of the new word at `bitcount==0`. Every frame is therefore coherent.
- Worst-case write-to-wire time: 2 cycles of arbitration, plus up to 25 cycles waiting for the boundary, plus one frame.
- Debounce latency: a persistent input change reaches `in_stable` DEBOUNCE frames after first capture. `in_changed` follows one cycle later.

## Structure
- Package `sr_io_pkg`:
  - `SR_WIDTH`=24, `FRAME_LAST`=24, `FRAME_FIRST`=0.
  - Arbiter state enum {ARB, ACK}.
  - Round-robin next-grant function.
- Sub-module `sr_in_debounce`: one instance, 24 parallel per-bit counters. Inputs are snapshot enable and `in_word`; outputs are `in_stable`, flip vector, `in_changed` and `change_mask`.

## Test plan
- Reset, then free-run `bitcount` 0..24. Required: `out_word`=0, `in_stable`=0, `req_ready`=0, and `frame_cnt` increments once per 25 cycles.
- Requester 0 writes mask 0x00001F, data 0x000015 mid-frame. Required: `req_ready[0]` pulses 1 cycle after valid, `pending`=0x000015, and `out_word` becomes 0x000015 only at the `bitcount==24` edge.
- Both requesters hold valid continuously, req0 mask/data 0x0000FF/0x0000AA and req1 0x00FF00/0x005500. Required: grants alternate 0,1,0,1 and `out_word`=0x0055AA after the next commit.
- Accept timed in the `bitcount==24` cycle. Required: the commit takes the old `pending`, and the new bits appear at the following boundary.
- Hold `in_word` bit 7 high for 3 frames with DEBOUNCE=3. Required: `in_stable[7]`=1 after the 3rd snapshot, and a single `in_changed` pulse with `change_mask`=0x000080. A 2-frame glitch on bit 8 produces no change.
- Assert `RST` during ACK. Required: no `req_ready` pulse, and all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/sr_io_pkg.sv
// Shared constants, arbiter state encoding and round-robin pick for the shift-register I/O scheduler.
// Pure definitions: no latency, no flow control.
package sr_io_pkg;

    localparam int SR_WIDTH    = 24;
    localparam int FRAME_LAST  = 24;
    localparam int FRAME_FIRST = 0;

    typedef enum logic {
        ARB = 1'b0,
        ACK = 1'b1
    } arb_state_e;

    // First set bit of valid at or after ptr, searching modulo nreq; scanning far-to-near lets the nearest win.
    function automatic logic [1:0] rr_next(input logic [3:0] valid,
                                           input logic [1:0] ptr,
                                           input int unsigned nreq);
        logic [1:0] w_pick;
        int unsigned idx;
        w_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (k < int'(nreq)) begin
                idx = (int'(ptr) + k) % nreq;
                if (valid[idx[1:0]]) begin
                    w_pick = idx[1:0];
                end
            end
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/sr_in_debounce.sv
// Per-bit frame debouncer: a bit flips after DEBOUNCE consecutive differing snapshots; in_changed one cycle later.
// Latency: in_stable on the snapshot edge, in_changed/change_mask one edge after; no backpressure.
module sr_in_debounce
    import sr_io_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic                CLK_IN,
    input  logic                RST,
    input  logic                i_snap_en,
    input  logic [SR_WIDTH-1:0] in_word,
    output logic [SR_WIDTH-1:0] in_stable,
    output logic [SR_WIDTH-1:0] flip,
    output logic                in_changed,
    output logic [SR_WIDTH-1:0] change_mask
);

    logic [1:0]          r_cnt [SR_WIDTH];
    logic [SR_WIDTH-1:0] r_stable;
    logic [SR_WIDTH-1:0] r_flip;
    logic                r_changed;
    logic [SR_WIDTH-1:0] r_mask;
    logic [SR_WIDTH-1:0] w_diff;
    logic [SR_WIDTH-1:0] w_flip;

    always_comb begin
        w_diff = in_word ^ r_stable;
        w_flip = '0;
        for (int n = 0; n < SR_WIDTH; n++) begin
            w_flip[n] = i_snap_en && w_diff[n] && (r_cnt[n] == 2'(DEBOUNCE - 1));
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            for (int n = 0; n < SR_WIDTH; n++) begin
                r_cnt[n] <= '0;
            end
            r_stable  <= '0;
            r_flip    <= '0;
            r_changed <= 1'b0;
            r_mask    <= '0;
        end else begin
            if (i_snap_en) begin
                for (int n = 0; n < SR_WIDTH; n++) begin
                    if (!w_diff[n] || w_flip[n]) begin
                        r_cnt[n] <= '0;
                    end else begin
                        r_cnt[n] <= r_cnt[n] + 2'd1;
                    end
                end
            end
            r_stable  <= r_stable ^ w_flip;
            r_flip    <= w_flip;
            r_changed <= |r_flip;
            if (|r_flip) begin
                r_mask <= r_flip;
            end
        end
    end

    assign in_stable   = r_stable;
    assign flip        = r_flip;
    assign in_changed  = r_changed;
    assign change_mask = r_mask;

endmodule

// File: rtl/sr_io_scheduler.sv
// Round-robin write arbiter merging into a shadow word committed at bitcount==24; debounced frame input snapshots.
// Latency: req_ready one cycle after valid is seen, at most one accept per 2 cycles; requesters hold until req_ready.
module sr_io_scheduler
    import sr_io_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DEBOUNCE = 3
) (
    input  logic                     CLK_IN,
    input  logic                     RST,
    input  logic [4:0]               bitcount,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [SR_WIDTH*NREQ-1:0] req_mask,
    input  logic [SR_WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [SR_WIDTH-1:0]      out_word,
    output logic [SR_WIDTH-1:0]      pending,
    input  logic [SR_WIDTH-1:0]      in_word,
    output logic [SR_WIDTH-1:0]      in_stable,
    output logic                     in_changed,
    output logic [SR_WIDTH-1:0]      change_mask,
    output logic [15:0]              frame_cnt
);

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    logic [1:0]          r_grant;
    logic [1:0]          r_ptr;
    logic [SR_WIDTH-1:0] r_pending;
    logic [SR_WIDTH-1:0] r_out;
    logic [15:0]         r_frame_cnt;
    logic [3:0]          w_valid4;
    logic [1:0]          w_pick;
    logic                w_ack;
    logic [SR_WIDTH-1:0] w_mask_g;
    logic [SR_WIDTH-1:0] w_data_g;
    logic                w_commit;
    logic                w_snap;
    logic [SR_WIDTH-1:0] w_flip;

    always_comb begin
        w_valid4             = '0;
        w_valid4[NREQ-1:0]   = req_valid;
        w_pick               = rr_next(w_valid4, r_ptr, NREQ);
        w_commit             = (bitcount == 5'(FRAME_LAST));
        w_snap               = (bitcount == 5'(FRAME_FIRST));
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB:     if (|req_valid) w_state_next = ACK;
            ACK:     w_state_next = ARB;
            default: w_state_next = ARB;
        endcase
    end

    // Gated by RST so a reset landing in the ACK cycle never shows an accept.
    always_comb begin
        w_ack     = (r_state == ACK) && !RST;
        req_ready = '0;
        w_mask_g  = '0;
        w_data_g  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == 2'(i)) begin
                req_ready[i] = w_ack;
                w_mask_g     = req_mask[SR_WIDTH*i +: SR_WIDTH];
                w_data_g     = req_data[SR_WIDTH*i +: SR_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            r_grant     <= '0;
            r_ptr       <= '0;
            r_pending   <= '0;
            r_out       <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (r_state == ARB && |req_valid) begin
                r_grant <= w_pick;
            end
            if (r_state == ACK) begin
                r_pending <= (r_pending & ~w_mask_g) | (w_data_g & w_mask_g);
                r_ptr     <= (r_grant == 2'(NREQ - 1)) ? 2'd0 : r_grant + 2'd1;
            end
            // Commit takes pending as it stood before any merge on this same edge.
            if (w_commit) begin
                r_out       <= r_pending;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    sr_in_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .CLK_IN      (CLK_IN),
        .RST         (RST),
        .i_snap_en   (w_snap),
        .in_word     (in_word),
        .in_stable   (in_stable),
        .flip        (w_flip),
        .in_changed  (in_changed),
        .change_mask (change_mask)
    );

    assign out_word  = r_out;
    assign pending   = r_pending;
    assign frame_cnt = r_frame_cnt;

endmodule
